// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads words from the icache and hands
// them to decode together with their PC and PC+4. A one-entry buffer catches an
// icache hit that arrives while decode is stalled, so the word is neither lost
// nor fetched twice.
module fetch_unit #(
    parameter int unsigned       WORD_W   = 32,
    parameter logic [WORD_W-1:0] PC_RESET = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic [WORD_W-1:0] instr_npc,
    output logic              instr_valid,
    output logic              halted
);

    typedef enum logic [1:0] {StFetch, StHold, StHalted} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] buf_instr_q, buf_instr_d;
    logic [WORD_W-1:0] buf_pc_q, buf_pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] instr_pc_q, instr_pc_d;
    logic [WORD_W-1:0] instr_npc_q, instr_npc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              halted_q, halted_d;

    logic [WORD_W-1:0] pc_inc;
    logic [WORD_W-1:0] buf_pc_inc;
    logic [WORD_W-1:0] redirect_tgt;
    logic              unused_redirect_lsb;

    // Word-aligned arithmetic; PC+4 wraps naturally at the top of the space.
    assign pc_inc              = pc_q + WORD_W'(4);
    assign buf_pc_inc          = buf_pc_q + WORD_W'(4);
    assign redirect_tgt        = {redirect_pc[WORD_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: redirect beats halt beats normal fetch; HALTED is terminal.
    always_comb begin
        state_d = state_q;
        if (state_q != StHalted) begin
            if (redirect) begin
                state_d = StFetch;
            end else if (halt) begin
                state_d = StHalted;
            end else begin
                unique case (state_q)
                    StFetch: if (ihit && stall) state_d = StHold;
                    StHold:  if (!stall)        state_d = StFetch;
                    default: ;
                endcase
            end
        end
    end

    // Datapath next values: PC, one-entry buffer and decode-facing registers.
    always_comb begin
        pc_d          = pc_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_npc_d   = instr_npc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        if (state_q != StHalted) begin
            if (redirect) begin
                // Flush: drop any same-cycle hit and the buffered word.
                pc_d          = redirect_tgt;
                buf_instr_d   = '0;
                buf_pc_d      = '0;
                instr_valid_d = 1'b0;
            end else if (halt) begin
                halted_d      = 1'b1;
                instr_valid_d = 1'b0;
            end else begin
                unique case (state_q)
                    StFetch: begin
                        if (ihit && !stall) begin
                            instr_d       = iload;
                            instr_pc_d    = pc_q;
                            instr_npc_d   = pc_inc;
                            instr_valid_d = 1'b1;
                            pc_d          = pc_inc;
                        end else if (ihit) begin
                            buf_instr_d = iload;
                            buf_pc_d    = pc_q;
                            pc_d        = pc_inc;
                        end else if (!stall) begin
                            instr_valid_d = 1'b0;
                        end
                    end
                    StHold: begin
                        if (!stall) begin
                            instr_d       = buf_instr_q;
                            instr_pc_d    = buf_pc_q;
                            instr_npc_d   = buf_pc_inc;
                            instr_valid_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q          <= PC_RESET;
            buf_instr_q   <= '0;
            buf_pc_q      <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_npc_q   <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_npc_q   <= instr_npc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    // Outputs: only read the icache while in FETCH and out of reset.
    always_comb begin
        iREN        = (state_q == StFetch) && !RST;
        iaddr       = pc_q;
        instr       = instr_q;
        instr_pc    = instr_pc_q;
        instr_npc   = instr_npc_q;
        instr_valid = instr_valid_q;
        halted      = halted_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit. The reference model treats fetch
// as a tiny queue: accepted icache words go straight to decode when it is
// free, otherwise wait in a single pending slot until decode frees up.
module tb_fetch_unit;

    localparam logic [31:0] PCR = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST, ihit, stall, redirect, halt;
    logic [31:0] iload, redirect_pc;
    logic        iREN, instr_valid, halted;
    logic [31:0] iaddr, instr, instr_pc, instr_npc;

    always #5 CLK = ~CLK;

    fetch_unit #(.WORD_W(32), .PC_RESET(PCR)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .iload       (iload),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_npc   (instr_npc),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (post-edge view).
    logic [31:0] m_pc;
    logic        m_halted, m_pend, m_valid;
    logic [31:0] m_pend_pc, m_pend_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the architectural rules for one clock edge with the current inputs.
    task automatic model_step();
        logic        deliver;
        exp_t        e;
        deliver = 1'b0;
        if (RST) begin
            m_pc = PCR; m_halted = 1'b0; m_pend = 1'b0; m_valid = 1'b0;
        end else if (m_halted) begin
            // nothing but reset leaves halt
        end else if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC; m_pend = 1'b0; m_valid = 1'b0;
        end else if (halt) begin
            m_halted = 1'b1; m_valid = 1'b0;
        end else begin
            if (m_pend) begin
                if (!stall) begin
                    e.pc = m_pend_pc; e.word = m_pend_word; deliver = 1'b1; m_pend = 1'b0;
                end
            end else if (ihit) begin
                if (!stall) begin
                    e.pc = m_pc; e.word = iload; deliver = 1'b1;
                end else begin
                    m_pend = 1'b1; m_pend_pc = m_pc; m_pend_word = iload;
                end
                m_pc = m_pc + 32'd4;
            end
            m_valid = deliver ? 1'b1 : (stall ? m_valid : 1'b0);
            if (deliver) sb.push_back(e);
        end
    endtask

    // One cycle: check post-edge state, then drive inputs for the next edge.
    task automatic cyc(input logic r, input logic h, input logic [31:0] w, input logic s,
                       input logic rd, input logic [31:0] rp, input logic hl);
        @(posedge CLK);
        #1;
        check("iaddr", iaddr, m_pc);
        check("iREN", 32'(iREN), 32'(!m_halted && !m_pend && !RST));
        check("halted", 32'(halted), 32'(m_halted));
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        RST = r; ihit = h; iload = w; stall = s; redirect = rd; redirect_pc = rp; halt = hl;
        model_step();
    endtask

    // Monitor: a valid word after an unstalled edge is a fresh delivery.
    logic stall_e;
    always @(posedge CLK) stall_e <= stall;

    always @(negedge CLK) begin
        if (instr_valid === 1'b1 && stall_e === 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery actual_pc=%h required=none at %0t",
                         instr_pc, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("instr", instr, e.word);
                check("instr_pc", instr_pc, e.pc);
                check("instr_npc", instr_npc, e.pc + 32'd4);
            end
        end
    end

    initial begin
        RST = 1'b1; ihit = 1'b0; iload = '0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        model_step();
        cyc(1, 0, 0, 0, 0, 0, 0);
        // Back-to-back hits from reset.
        cyc(0, 1, 32'h2001_0005, 0, 0, 0, 0);
        cyc(0, 1, 32'h2002_0003, 0, 0, 0, 0);
        // Hit at pc=0x8 under a three-cycle stall, then release.
        cyc(0, 1, 32'h2003_0008, 1, 0, 0, 0);
        cyc(0, 1, 32'hDEAD_0001, 1, 0, 0, 0);
        cyc(0, 1, 32'hDEAD_0002, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h2004_000C, 0, 0, 0, 0);
        // Redirect from HOLD with a same-cycle stalled hit.
        cyc(0, 1, 32'h1111_1111, 1, 0, 0, 0);
        cyc(0, 1, 32'h2222_2222, 1, 1, 32'h0000_0103, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h3333_0100, 0, 0, 0, 0);
        // Halt at pc=0x20, then inputs that must be ignored, then reset.
        cyc(0, 0, 0, 0, 1, 32'h0000_0020, 0);
        cyc(0, 1, 32'h4444_4444, 0, 0, 0, 1);
        cyc(0, 1, 32'h5555_5555, 0, 1, 32'h0000_0400, 0);
        cyc(0, 1, 32'h6666_6666, 1, 0, 0, 1);
        cyc(0, 1, 32'h7777_7777, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        // Halt and redirect together: redirect wins.
        cyc(0, 1, 32'h8888_8888, 0, 1, 32'h0000_0200, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // PC wrap at the top of the address space.
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        cyc(0, 1, 32'h9999_FFFC, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rp;
            rp = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                          : 32'($urandom);
            cyc(($urandom_range(99) < 2), ($urandom_range(99) < 70), 32'($urandom),
                ($urandom_range(99) < 40), ($urandom_range(99) < 5), rp,
                ($urandom_range(99) < 1));
        end
        // Drain: release stall so any buffered word is delivered.
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
